// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory port between fetch and load/store.
// One transaction in flight; D-side wins ties unless the I-side has starved.
//
// Ports:
//   clk, rst             core clock, asynchronous active-high reset
//   Ifu_Req/Addr/Kill    fetch request (word read) and fetch redirect
//   Ifu_Ack/Instr        one-cycle fetch response
//   Icache_StallReq      fetch side waiting
//   Mem_Req/Rd/Width/Addr/WrData  load/store request
//   Mem_Ack/RdData       one-cycle load/store completion
//   Dcache_StallReq      load/store side waiting
//   Bus_Valid/Rd/Width/Addr/WrData  registered bus request
//   Bus_Ready            bus accepts the request
//   Bus_RespValid/RdData bus response

module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  Ifu_Req,
    input  logic [ADDR_WIDTH-1:0] Ifu_Addr,
    input  logic                  Ifu_Kill,
    output logic                  Ifu_Ack,
    output logic [DATA_WIDTH-1:0] Ifu_Instr,
    output logic                  Icache_StallReq,

    input  logic                  Mem_Req,
    input  logic                  Mem_Rd,
    input  logic [1:0]            Mem_Width,
    input  logic [ADDR_WIDTH-1:0] Mem_Addr,
    input  logic [DATA_WIDTH-1:0] Mem_WrData,
    output logic                  Mem_Ack,
    output logic [DATA_WIDTH-1:0] Mem_RdData,
    output logic                  Dcache_StallReq,

    output logic                  Bus_Valid,
    output logic                  Bus_Rd,
    output logic [1:0]            Bus_Width,
    output logic [ADDR_WIDTH-1:0] Bus_Addr,
    output logic [DATA_WIDTH-1:0] Bus_WrData,
    input  logic                  Bus_Ready,
    input  logic                  Bus_RespValid,
    input  logic [DATA_WIDTH-1:0] Bus_RdData
);

    typedef enum logic [2:0] {
        IDLE,
        REQ_I,
        REQ_D,
        WAIT_I,
        WAIT_D
    } state_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_e                state_q, state_d;
    logic [3:0]            starve_q, starve_d;
    logic                  drop_q, drop_d;
    logic                  valid_q, valid_d;
    logic                  rd_q, rd_d;
    logic [1:0]            width_q, width_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic i_ok;
    logic pick_i;
    logic pick_d;

    // A fetch killed in the same cycle it would be granted is not worth
    // starting; the D side may still take the bus.
    assign i_ok   = Ifu_Req && !Ifu_Kill;
    assign pick_i = i_ok && (!Mem_Req || starve_q == LIMIT);
    assign pick_d = Mem_Req && !pick_i;

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        drop_d   = drop_q;
        valid_d  = valid_q;
        rd_d     = rd_q;
        width_d  = width_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;

        unique case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (!Ifu_Req) begin
                    starve_d = 4'd0;
                end
                unique case (1'b1)
                    pick_i: begin
                        state_d  = REQ_I;
                        valid_d  = 1'b1;
                        rd_d     = 1'b1;
                        width_d  = 2'd2;
                        addr_d   = Ifu_Addr;
                        wdata_d  = '0;
                        starve_d = 4'd0;
                    end
                    pick_d: begin
                        state_d = REQ_D;
                        valid_d = 1'b1;
                        rd_d    = Mem_Rd;
                        width_d = Mem_Width;
                        addr_d  = Mem_Addr;
                        wdata_d = Mem_WrData;
                        // Only D grants that overtake a waiting fetch count.
                        if (Ifu_Req && starve_q != LIMIT) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
            REQ_I: begin
                // The request is already on the bus and cannot be
                // withdrawn; remember to swallow its response instead.
                if (Ifu_Kill) begin
                    drop_d = 1'b1;
                end
                if (Bus_Ready) begin
                    state_d = WAIT_I;
                    valid_d = 1'b0;
                end
            end
            REQ_D: begin
                if (Bus_Ready) begin
                    state_d = WAIT_D;
                    valid_d = 1'b0;
                end
            end
            WAIT_I: begin
                if (Ifu_Kill) begin
                    drop_d = 1'b1;
                end
                if (Bus_RespValid) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                end
            end
            WAIT_D: begin
                if (Bus_RespValid) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                drop_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            starve_q <= 4'd0;
            drop_q   <= 1'b0;
            valid_q  <= 1'b0;
            rd_q     <= 1'b0;
            width_q  <= 2'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            drop_q   <= drop_d;
            valid_q  <= valid_d;
            rd_q     <= rd_d;
            width_q  <= width_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    // A kill arriving together with the response must also suppress it,
    // so the live Ifu_Kill is folded in alongside the registered flag.
    assign Ifu_Ack = (state_q == WAIT_I) && Bus_RespValid
                   && !drop_q && !Ifu_Kill;
    assign Mem_Ack = (state_q == WAIT_D) && Bus_RespValid;

    assign Ifu_Instr  = Ifu_Ack ? Bus_RdData : '0;
    // Stores complete with no data; rd_q still describes the
    // transaction being acknowledged.
    assign Mem_RdData = (Mem_Ack && rd_q) ? Bus_RdData : '0;

    assign Icache_StallReq = Ifu_Req && !Ifu_Ack;
    assign Dcache_StallReq = Mem_Req && !Mem_Ack;

    assign Bus_Valid  = valid_q;
    assign Bus_Rd     = rd_q;
    assign Bus_Width  = width_q;
    assign Bus_Addr   = addr_q;
    assign Bus_WrData = wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed bench for mem_bus_arbiter.
// Inputs change 1ns after the rising edge; outputs are sampled 2ns after it.

module tb_mem_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          Ifu_Req;
    logic [AW-1:0] Ifu_Addr;
    logic          Ifu_Kill;
    logic          Ifu_Ack;
    logic [DW-1:0] Ifu_Instr;
    logic          Icache_StallReq;
    logic          Mem_Req;
    logic          Mem_Rd;
    logic [1:0]    Mem_Width;
    logic [AW-1:0] Mem_Addr;
    logic [DW-1:0] Mem_WrData;
    logic          Mem_Ack;
    logic [DW-1:0] Mem_RdData;
    logic          Dcache_StallReq;
    logic          Bus_Valid;
    logic          Bus_Rd;
    logic [1:0]    Bus_Width;
    logic [AW-1:0] Bus_Addr;
    logic [DW-1:0] Bus_WrData;
    logic          Bus_Ready;
    logic          Bus_RespValid;
    logic [DW-1:0] Bus_RdData;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .STARVE_LIMIT(4),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .Ifu_Req(Ifu_Req),
        .Ifu_Addr(Ifu_Addr),
        .Ifu_Kill(Ifu_Kill),
        .Ifu_Ack(Ifu_Ack),
        .Ifu_Instr(Ifu_Instr),
        .Icache_StallReq(Icache_StallReq),
        .Mem_Req(Mem_Req),
        .Mem_Rd(Mem_Rd),
        .Mem_Width(Mem_Width),
        .Mem_Addr(Mem_Addr),
        .Mem_WrData(Mem_WrData),
        .Mem_Ack(Mem_Ack),
        .Mem_RdData(Mem_RdData),
        .Dcache_StallReq(Dcache_StallReq),
        .Bus_Valid(Bus_Valid),
        .Bus_Rd(Bus_Rd),
        .Bus_Width(Bus_Width),
        .Bus_Addr(Bus_Addr),
        .Bus_WrData(Bus_WrData),
        .Bus_Ready(Bus_Ready),
        .Bus_RespValid(Bus_RespValid),
        .Bus_RdData(Bus_RdData)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        Ifu_Req = 0; Ifu_Addr = '0; Ifu_Kill = 0;
        Mem_Req = 0; Mem_Rd = 0; Mem_Width = 0;
        Mem_Addr = '0; Mem_WrData = '0;
        Bus_Ready = 0; Bus_RespValid = 0; Bus_RdData = '0;
        repeat (2) @(posedge clk);
        #2;
        n_cmp++;
        if ({Bus_Valid, Bus_Rd, Bus_Width} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_ctl: got %b want 0000",
                     {Bus_Valid, Bus_Rd, Bus_Width});
        end
        n_cmp++;
        if ({Bus_Addr, Bus_WrData} !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_fields: got %h want 0",
                     {Bus_Addr, Bus_WrData});
        end
        n_cmp++;
        if ({Ifu_Ack, Mem_Ack, Icache_StallReq, Dcache_StallReq} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_ack: got %b want 0000",
                     {Ifu_Ack, Mem_Ack, Icache_StallReq, Dcache_StallReq});
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        step();
        Ifu_Req = 1; Ifu_Addr = 32'h100; Bus_Ready = 1;
        #1;
        n_cmp++;
        if ({Icache_StallReq, Bus_Valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL fetch_c0: got %b want 10",
                     {Icache_StallReq, Bus_Valid});
        end
        step();
        #1;
        n_cmp++;
        if ({Bus_Valid, Bus_Rd, Bus_Width, Bus_Addr} !== {1'b1, 1'b1, 2'd2, 32'h100}) begin
            n_bad++;
            $display("FAIL fetch_c1_bus: got v%b r%b w%0d a%h want v1 r1 w2 a100",
                     Bus_Valid, Bus_Rd, Bus_Width, Bus_Addr);
        end
        n_cmp++;
        if ({Icache_StallReq, Ifu_Ack} !== 2'b10) begin
            n_bad++;
            $display("FAIL fetch_c1_stall: got %b want 10",
                     {Icache_StallReq, Ifu_Ack});
        end
        step();
        Bus_RespValid = 1; Bus_RdData = 32'h13;
        #1;
        n_cmp++;
        if ({Ifu_Ack, Icache_StallReq, Ifu_Instr} !== {2'b10, 32'h13}) begin
            n_bad++;
            $display("FAIL fetch_c2_ack: got a%b s%b i%h want a1 s0 i13",
                     Ifu_Ack, Icache_StallReq, Ifu_Instr);
        end
        step();
        Ifu_Req = 0; Bus_RespValid = 0; Bus_RdData = '0;
        #1;
        n_cmp++;
        if ({Ifu_Ack, Bus_Valid, Ifu_Instr} !== 34'h0) begin
            n_bad++;
            $display("FAIL fetch_c3_idle: got a%b v%b i%h want 0 0 0",
                     Ifu_Ack, Bus_Valid, Ifu_Instr);
        end
    endtask

    task automatic test_store_wait();
        step();
        Mem_Req = 1; Mem_Rd = 0; Mem_Width = 0;
        Mem_Addr = 32'h2003; Mem_WrData = 32'hA5; Bus_Ready = 0;
        for (int c = 1; c <= 6; c++) begin
            step();
            Bus_Ready     = (c == 3);
            Bus_RespValid = (c == 2) || (c == 6);
            Bus_RdData    = 32'hDEADBEEF;
            #1;
            if (c <= 3) begin
                n_cmp++;
                if ({Bus_Valid, Bus_Rd, Bus_Width, Bus_Addr, Bus_WrData}
                    !== {1'b1, 1'b0, 2'd0, 32'h2003, 32'hA5}) begin
                    n_bad++;
                    $display("FAIL store_req_c%0d: got v%b r%b w%0d a%h d%h want v1 r0 w0 a2003 da5",
                             c, Bus_Valid, Bus_Rd, Bus_Width, Bus_Addr, Bus_WrData);
                end
            end
            if (c <= 5) begin
                n_cmp++;
                if ({Mem_Ack, Dcache_StallReq} !== 2'b01) begin
                    n_bad++;
                    $display("FAIL store_wait_c%0d: got ack%b stall%b want ack0 stall1",
                             c, Mem_Ack, Dcache_StallReq);
                end
            end else begin
                n_cmp++;
                if ({Mem_Ack, Dcache_StallReq, Mem_RdData} !== {2'b10, 32'h0}) begin
                    n_bad++;
                    $display("FAIL store_ack_c6: got ack%b stall%b d%h want ack1 stall0 d0",
                             Mem_Ack, Dcache_StallReq, Mem_RdData);
                end
            end
        end
        step();
        Mem_Req = 0; Bus_RespValid = 0; Bus_Ready = 0; Bus_RdData = '0;
        #1;
        n_cmp++;
        if ({Mem_Ack, Bus_Valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL store_idle: got %b want 00", {Mem_Ack, Bus_Valid});
        end
    endtask

    task automatic test_simultaneous();
        step();
        Ifu_Req = 1; Ifu_Addr = 32'h200;
        Mem_Req = 1; Mem_Rd = 1; Mem_Width = 2; Mem_Addr = 32'h3000;
        Bus_Ready = 1;
        step();
        #1;
        n_cmp++;
        if ({Bus_Valid, Bus_Addr} !== {1'b1, 32'h3000}) begin
            n_bad++;
            $display("FAIL both_c1: got v%b a%h want v1 a3000", Bus_Valid, Bus_Addr);
        end
        step();
        Bus_RespValid = 1; Bus_RdData = 32'h11112222;
        #1;
        n_cmp++;
        if ({Mem_Ack, Ifu_Ack, Icache_StallReq, Mem_RdData} !== {3'b101, 32'h11112222}) begin
            n_bad++;
            $display("FAIL both_c2_dack: got m%b i%b s%b d%h want m1 i0 s1 d11112222",
                     Mem_Ack, Ifu_Ack, Icache_StallReq, Mem_RdData);
        end
        step();
        Mem_Req = 0; Bus_RespValid = 0;
        #1;
        n_cmp++;
        if (Bus_Valid !== 1'b0) begin
            n_bad++;
            $display("FAIL both_c3_idle: got v%b want v0", Bus_Valid);
        end
        step();
        #1;
        n_cmp++;
        if ({Bus_Valid, Bus_Width, Bus_Addr} !== {1'b1, 2'd2, 32'h200}) begin
            n_bad++;
            $display("FAIL both_c4_ireq: got v%b w%0d a%h want v1 w2 a200",
                     Bus_Valid, Bus_Width, Bus_Addr);
        end
        step();
        Bus_RespValid = 1; Bus_RdData = 32'h33;
        #1;
        n_cmp++;
        if ({Ifu_Ack, Ifu_Instr} !== {1'b1, 32'h33}) begin
            n_bad++;
            $display("FAIL both_c5_iack: got a%b i%h want a1 i33", Ifu_Ack, Ifu_Instr);
        end
        step();
        Ifu_Req = 0; Bus_RespValid = 0; Bus_RdData = '0;
    endtask

    task automatic test_starvation();
        int d_cnt;
        int i_seen;
        int d_run[2];
        d_cnt = 0; i_seen = 0; d_run[0] = -1; d_run[1] = -1;
        step();
        Ifu_Req = 1; Ifu_Addr = 32'h400;
        Mem_Req = 1; Mem_Rd = 1; Mem_Width = 2; Mem_Addr = 32'h5000;
        Bus_Ready = 1; Bus_RespValid = 1; Bus_RdData = 32'h42;
        for (int c = 0; c < 80 && i_seen < 2; c++) begin
            #1;
            if (Mem_Ack) d_cnt++;
            if (Ifu_Ack) begin
                d_run[i_seen] = d_cnt;
                i_seen++;
                d_cnt = 0;
            end
            step();
        end
        Ifu_Req = 0; Mem_Req = 0; Bus_RespValid = 0; Bus_RdData = '0;
        n_cmp++;
        if (i_seen !== 2) begin
            n_bad++;
            $display("FAIL starve_timeout: got %0d I grants want 2", i_seen);
        end
        n_cmp++;
        if (d_run[0] !== 4) begin
            n_bad++;
            $display("FAIL starve_first: got %0d D grants want 4", d_run[0]);
        end
        n_cmp++;
        if (d_run[1] !== 4) begin
            n_bad++;
            $display("FAIL starve_rearm: got %0d D grants want 4", d_run[1]);
        end
    endtask

    task automatic test_kill();
        step();
        Ifu_Req = 1; Ifu_Addr = 32'h600; Bus_Ready = 0;
        step();
        Ifu_Kill = 1;
        #1;
        n_cmp++;
        if ({Bus_Valid, Ifu_Ack} !== 2'b10) begin
            n_bad++;
            $display("FAIL kill_req: got %b want 10", {Bus_Valid, Ifu_Ack});
        end
        step();
        Ifu_Kill = 0; Ifu_Req = 0; Bus_Ready = 1;
        #1;
        n_cmp++;
        if ({Bus_Valid, Bus_Addr} !== {1'b1, 32'h600}) begin
            n_bad++;
            $display("FAIL kill_hold: got v%b a%h want v1 a600", Bus_Valid, Bus_Addr);
        end
        step();
        Bus_Ready = 0; Bus_RespValid = 1; Bus_RdData = 32'h77;
        #1;
        n_cmp++;
        if ({Ifu_Ack, Ifu_Instr} !== 33'h0) begin
            n_bad++;
            $display("FAIL kill_swallow: got a%b i%h want a0 i0", Ifu_Ack, Ifu_Instr);
        end
        step();
        Bus_RespValid = 0;
        step();
        Ifu_Req = 1; Ifu_Addr = 32'h700; Bus_Ready = 1;
        step();
        #1;
        n_cmp++;
        if ({Bus_Valid, Bus_Addr} !== {1'b1, 32'h700}) begin
            n_bad++;
            $display("FAIL kill_refetch: got v%b a%h want v1 a700", Bus_Valid, Bus_Addr);
        end
        step();
        Bus_RespValid = 1; Bus_RdData = 32'h99;
        #1;
        n_cmp++;
        if ({Ifu_Ack, Ifu_Instr} !== {1'b1, 32'h99}) begin
            n_bad++;
            $display("FAIL kill_refetch_ack: got a%b i%h want a1 i99", Ifu_Ack, Ifu_Instr);
        end
        step();
        Bus_RespValid = 0; Ifu_Addr = 32'h800;
        step();
        step();
        Bus_RespValid = 1; Ifu_Kill = 1; Bus_RdData = 32'hAB;
        #1;
        n_cmp++;
        if ({Ifu_Ack, Ifu_Instr} !== 33'h0) begin
            n_bad++;
            $display("FAIL kill_coincident: got a%b i%h want a0 i0", Ifu_Ack, Ifu_Instr);
        end
        step();
        Ifu_Kill = 0; Ifu_Req = 0; Bus_RespValid = 0; Bus_RdData = '0;
        #1;
        n_cmp++;
        if ({Bus_Valid, Ifu_Ack} !== 2'b00) begin
            n_bad++;
            $display("FAIL kill_idle: got %b want 00", {Bus_Valid, Ifu_Ack});
        end
    endtask

    task automatic test_reset_mid();
        step();
        Mem_Req = 1; Mem_Rd = 1; Mem_Width = 2; Mem_Addr = 32'h9000;
        Bus_Ready = 1;
        step();
        step();
        Bus_RespValid = 1; Bus_RdData = 32'h1234;
        #1;
        n_cmp++;
        if (Mem_Ack !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_pre: got ack%b want ack1", Mem_Ack);
        end
        rst = 1;
        #1;
        n_cmp++;
        if ({Mem_Ack, Ifu_Ack, Bus_Valid, Dcache_StallReq} !== 4'b0001) begin
            n_bad++;
            $display("FAIL rstmid_async: got %b want 0001",
                     {Mem_Ack, Ifu_Ack, Bus_Valid, Dcache_StallReq});
        end
        n_cmp++;
        if ({Bus_Rd, Bus_Width, Bus_Addr} !== 35'h0) begin
            n_bad++;
            $display("FAIL rstmid_fields: got r%b w%0d a%h want 0 0 0",
                     Bus_Rd, Bus_Width, Bus_Addr);
        end
        Bus_RespValid = 0; Mem_Addr = 32'hA000;
        step();
        rst = 0;
        #1;
        n_cmp++;
        if (Bus_Valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_idle: got v%b want v0", Bus_Valid);
        end
        step();
        #1;
        n_cmp++;
        if ({Bus_Valid, Bus_Rd, Bus_Addr} !== {2'b11, 32'hA000}) begin
            n_bad++;
            $display("FAIL rstmid_newreq: got v%b r%b a%h want v1 r1 aa000",
                     Bus_Valid, Bus_Rd, Bus_Addr);
        end
        step();
        Bus_RespValid = 1; Bus_RdData = 32'h5555;
        #1;
        n_cmp++;
        if ({Mem_Ack, Mem_RdData} !== {1'b1, 32'h5555}) begin
            n_bad++;
            $display("FAIL rstmid_newack: got a%b d%h want a1 d5555", Mem_Ack, Mem_RdData);
        end
        step();
        Mem_Req = 0; Bus_RespValid = 0; Bus_Ready = 0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_wait();
        test_simultaneous();
        test_starvation();
        test_kill();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
